// File: rtl/bbox_pkg.sv
// Shared types and constants for the frame bounding-box scanner.
// Optional feature macro used by the block: BBOX_COUNT_EN (foreground pixel count).
package bbox_pkg;

    localparam int FRAME_W = 640;
    localparam int FRAME_H = 480;

    typedef logic [8:0]  row_t;
    typedef logic [9:0]  col_t;
    typedef logic [18:0] count_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic col_t min_col(input col_t a, input col_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic col_t max_col(input col_t a, input col_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bbox_chunk_scan.sv
// Combinational analysis of one CHUNK-wide slice of a frame row: whether any
// pixel is set, the lowest and highest set index within the slice, and (when
// BBOX_COUNT_EN is defined) the number of set pixels.
module bbox_chunk_scan
    import bbox_pkg::*;
#(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] bits,
    output logic             any,
    output col_t             first,
    output col_t             last
`ifdef BBOX_COUNT_EN
    ,
    output col_t             ones
`endif
);

    assign any = |bits;

    // Priority search: the descending loop leaves the lowest set index, the ascending one the highest.
    always_comb begin
        first = '0;
        last  = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (bits[i]) first = col_t'(i);
        end
        for (int i = 0; i < CHUNK; i++) begin
            if (bits[i]) last = col_t'(i);
        end
    end

`ifdef BBOX_COUNT_EN
    // Population count of the slice; a CHUNK of up to 640 fits the column width.
    always_comb begin
        ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            ones = ones + col_t'(bits[i]);
        end
    end
`endif

endmodule

// File: rtl/frame_bbox_scanner.sv
// Scans a binarised 640x480 frame CHUNK columns per cycle after a start pulse
// and publishes the foreground bounding box (and, with BBOX_COUNT_EN defined,
// the foreground pixel count) together with a one-cycle done pulse.
module frame_bbox_scanner
    import bbox_pkg::*;
#(
    parameter int CHUNK = 64
) (
    input  logic                               iCLK,
    input  logic                               iRST_n,
    input  logic                               iSTART,
    input  logic [FRAME_H-1:0][0:FRAME_W-1]    iFLASH,
    output logic                               oBUSY,
    output logic                               oDONE,
    output logic                               oVALID_BOX,
    output row_t                               oTOP,
    output row_t                               oBOTTOM,
    output col_t                               oLEFT,
    output col_t                               oRIGHT,
    output count_t                             oCOUNT,
    output logic                               oDROP
);

    localparam col_t LAST_BASE = col_t'(FRAME_W - CHUNK);
    localparam row_t LAST_ROW  = row_t'(FRAME_H - 1);
    localparam col_t STEP      = col_t'(CHUNK);

    state_t state_reg, state_next;
    row_t   row_reg, row_next;
    col_t   base_reg, base_next;
    logic   found_reg, found_next;
    row_t   top_reg, top_next, bottom_reg, bottom_next;
    col_t   left_reg, left_next, right_reg, right_next;
    logic   done_reg, done_next;
    logic   drop_reg, drop_next;
    logic   out_valid_reg, out_valid_next;
    row_t   out_top_reg, out_top_next, out_bottom_reg, out_bottom_next;
    col_t   out_left_reg, out_left_next, out_right_reg, out_right_next;

    logic [FRAME_W-1:0] row_bits;
    logic [CHUNK-1:0]   slice;
    logic               any;
    col_t               first, last, abs_first, abs_last;

    // Current row, re-packed so that bit c of row_bits is column c.
    generate
        for (genvar gi = 0; gi < FRAME_W; gi++) begin : g_row
            assign row_bits[gi] = iFLASH[row_reg][gi];
        end
    endgenerate

    assign slice     = row_bits[base_reg +: CHUNK];
    assign abs_first = base_reg + first;
    assign abs_last  = base_reg + last;

`ifdef BBOX_COUNT_EN
    col_t   ones;
    count_t count_reg, count_next;
    count_t out_count_reg, out_count_next;
`endif

    bbox_chunk_scan #(
        .CHUNK (CHUNK)
    ) u_chunk_scan (
        .bits  (slice),
        .any   (any),
        .first (first),
        .last  (last)
`ifdef BBOX_COUNT_EN
        ,
        .ones  (ones)
`endif
    );

    // FSM state register.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // Next state, scan counters, working accumulators and published results.
    always_comb begin
        state_next      = state_reg;
        row_next        = row_reg;
        base_next       = base_reg;
        found_next      = found_reg;
        top_next        = top_reg;
        bottom_next     = bottom_reg;
        left_next       = left_reg;
        right_next      = right_reg;
        done_next       = 1'b0;
        drop_next       = drop_reg;
        out_valid_next  = out_valid_reg;
        out_top_next    = out_top_reg;
        out_bottom_next = out_bottom_reg;
        out_left_next   = out_left_reg;
        out_right_next  = out_right_reg;
`ifdef BBOX_COUNT_EN
        count_next      = count_reg;
        out_count_next  = out_count_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (iSTART) begin
                    state_next  = SCAN;
                    row_next    = '0;
                    base_next   = '0;
                    found_next  = 1'b0;
                    top_next    = '0;
                    bottom_next = '0;
                    left_next   = '0;
                    right_next  = '0;
`ifdef BBOX_COUNT_EN
                    count_next  = '0;
`endif
                end
            end
            SCAN: begin
                // A start during a scan is discarded but remembered until reset.
                if (iSTART) drop_next = 1'b1;
`ifdef BBOX_COUNT_EN
                count_next = count_reg + count_t'(ones);
`endif
                if (any) begin
                    if (!found_reg) begin
                        top_next   = row_reg;
                        left_next  = abs_first;
                        right_next = abs_last;
                    end else begin
                        left_next  = min_col(left_reg, abs_first);
                        right_next = max_col(right_reg, abs_last);
                    end
                    bottom_next = row_reg;
                    found_next  = 1'b1;
                end
                if (base_reg == LAST_BASE) begin
                    base_next = '0;
                    if (row_reg == LAST_ROW) begin
                        // Publish the accumulators including this final chunk.
                        state_next      = IDLE;
                        done_next       = 1'b1;
                        out_valid_next  = found_next;
                        out_top_next    = top_next;
                        out_bottom_next = bottom_next;
                        out_left_next   = left_next;
                        out_right_next  = right_next;
`ifdef BBOX_COUNT_EN
                        out_count_next  = count_next;
`endif
                    end else begin
                        row_next = row_reg + 1'b1;
                    end
                end else begin
                    base_next = base_reg + STEP;
                end
            end
        endcase
    end

    // Datapath registers; the asynchronous reset aborts any scan without a done pulse.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            row_reg        <= '0;
            base_reg       <= '0;
            found_reg      <= 1'b0;
            top_reg        <= '0;
            bottom_reg     <= '0;
            left_reg       <= '0;
            right_reg      <= '0;
            done_reg       <= 1'b0;
            drop_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_top_reg    <= '0;
            out_bottom_reg <= '0;
            out_left_reg   <= '0;
            out_right_reg  <= '0;
`ifdef BBOX_COUNT_EN
            count_reg      <= '0;
            out_count_reg  <= '0;
`endif
        end else begin
            row_reg        <= row_next;
            base_reg       <= base_next;
            found_reg      <= found_next;
            top_reg        <= top_next;
            bottom_reg     <= bottom_next;
            left_reg       <= left_next;
            right_reg      <= right_next;
            done_reg       <= done_next;
            drop_reg       <= drop_next;
            out_valid_reg  <= out_valid_next;
            out_top_reg    <= out_top_next;
            out_bottom_reg <= out_bottom_next;
            out_left_reg   <= out_left_next;
            out_right_reg  <= out_right_next;
`ifdef BBOX_COUNT_EN
            count_reg      <= count_next;
            out_count_reg  <= out_count_next;
`endif
        end
    end

    assign oBUSY      = (state_reg == SCAN);
    assign oDONE      = done_reg;
    assign oDROP      = drop_reg;
    assign oVALID_BOX = out_valid_reg;
    assign oTOP       = out_top_reg;
    assign oBOTTOM    = out_bottom_reg;
    assign oLEFT      = out_left_reg;
    assign oRIGHT     = out_right_reg;
`ifdef BBOX_COUNT_EN
    assign oCOUNT     = out_count_reg;
`else
    assign oCOUNT     = '0;
`endif

endmodule

// File: tb/tb_frame_bbox_scanner.sv
// Scoreboard bench for frame_bbox_scanner: each scan's expected result is
// computed from the frame by a pixel-loop model and queued; a monitor pops and
// compares whenever oDONE is seen. Honours BBOX_COUNT_EN for the count output.
module tb_frame_bbox_scanner;
    import bbox_pkg::*;

    localparam int CHUNK = 64;
    localparam int N     = FRAME_W * FRAME_H / CHUNK;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [FRAME_H-1:0][0:FRAME_W-1] frame;

    logic   busy, done, valid_box, drop;
    row_t   top, bottom;
    col_t   left, right;
    count_t count;

    frame_bbox_scanner #(
        .CHUNK (CHUNK)
    ) dut (
        .iCLK       (clk),
        .iRST_n     (rst_n),
        .iSTART     (start),
        .iFLASH     (frame),
        .oBUSY      (busy),
        .oDONE      (done),
        .oVALID_BOX (valid_box),
        .oTOP       (top),
        .oBOTTOM    (bottom),
        .oLEFT      (left),
        .oRIGHT     (right),
        .oCOUNT     (count),
        .oDROP      (drop)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit     valid;
        int     top;
        int     bottom;
        int     left;
        int     right;
        int     count;
        longint done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t last_res = '{default: 0};
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: plain pixel loop over the whole frame.
    task automatic model(output exp_t e);
        e = '{default: 0};
        for (int r = 0; r < FRAME_H; r++) begin
            for (int c = 0; c < FRAME_W; c++) begin
                if (frame[r][c]) begin
                    if (!e.valid) begin
                        e.top   = r;
                        e.left  = c;
                        e.right = c;
                    end
                    e.valid  = 1'b1;
                    e.bottom = r;
                    if (c < e.left)  e.left  = c;
                    if (c > e.right) e.right = c;
                    e.count++;
                end
            end
        end
`ifndef BBOX_COUNT_EN
        e.count = 0;
`endif
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, "_valid"},  valid_box, e.valid);
        chk({tag, "_top"},    top,       e.top);
        chk({tag, "_bottom"}, bottom,    e.bottom);
        chk({tag, "_left"},   left,      e.left);
        chk({tag, "_right"},  right,     e.right);
        chk({tag, "_count"},  count,     e.count);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                $display("scan done at cycle %0d: valid=%0d box=(%0d,%0d,%0d,%0d) count=%0d",
                         cyc, valid_box, top, bottom, left, right, count);
                chk("done_cycle", cyc, mon_e.done_cyc);
                chk("busy_at_done", busy, 0);
                check_outputs("result", mon_e);
                last_res = mon_e;
            end
        end
    end

    task automatic run_scan(input bit drop_pulse);
        exp_t   e;
        longint e0;
        int     guard;
        model(e);
        @(negedge clk);
        start = 1'b1;
        e0 = cyc + 1;
        e.done_cyc = e0 + N;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (drop_pulse) begin
            while (cyc < e0 + 9) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (40) @(negedge clk);
        check_outputs("hold", last_res);
        guard = 0;
        while (sb.size() != 0 && guard < N + 50) begin
            @(negedge clk);
            guard++;
        end
        chk("done_within_budget", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin
        #(1_500_000);
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r0, r1, c0, c1;
        frame = '0;
        repeat (3) @(negedge clk);
        check_outputs("reset", last_res);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_drop", drop, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single pixel.
        frame = '0;
        frame[100][200] = 1'b1;
        run_scan(1'b0);

        // Chunk-boundary pixels, with a second start at E0+10 that must be dropped.
        chk("drop_before", drop, 0);
        frame = '0;
        frame[5][63]  = 1'b1;
        frame[5][64]  = 1'b1;
        frame[479][0] = 1'b1;
        frame[0][639] = 1'b1;
        run_scan(1'b1);
        repeat (5) @(negedge clk);
        chk("drop_sticky", drop, 1);

        // Reset in the middle of a scan: outputs clear at once and no done follows.
        frame = '1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        last_res = '{default: 0};
        check_outputs("async_reset", last_res);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_drop", drop, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 20) @(negedge clk);
        chk("idle_after_reset", busy, 0);

        // Empty frame, then all-ones frame.
        frame = '0;
        run_scan(1'b0);
        frame = '1;
        run_scan(1'b0);

        // Random sparse pixels.
        frame = '0;
        k = $urandom_range(1, 20);
        for (int i = 0; i < k; i++)
            frame[$urandom_range(0, FRAME_H - 1)][$urandom_range(0, FRAME_W - 1)] = 1'b1;
        run_scan(1'b0);

        // Random rectangle with sparse random fill.
        frame = '0;
        r0 = $urandom_range(0, 239);
        r1 = $urandom_range(240, FRAME_H - 1);
        c0 = $urandom_range(0, 319);
        c1 = $urandom_range(320, FRAME_W - 1);
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++)
                frame[r][c] = (($urandom % 8) == 0);
        run_scan(1'b0);

        // Dense random band.
        frame = '0;
        for (int r = 30; r < 400; r++)
            for (int c = 0; c < FRAME_W; c++)
                frame[r][c] = (($urandom % 2) == 0);
        run_scan(1'b0);

        repeat (3) @(negedge clk);
        chk("drop_cleared_stays", drop, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_bbox_scanner.md
# frame_bbox_scanner

Consumes the binarised 640x480 frame held by the serial-to-parallel frame buffer and computes the foreground bounding box and foreground pixel count. It is triggered by the buffer's one-cycle finished pulse. It scans the parallel frame CHUNK bits per cycle and presents registered results with a one-cycle done pulse to the downstream tracking/display logic. Results hold until the next completed scan.

## Interface
Parameters:
- CHUNK, 64, columns examined per cycle; must divide 640 (legal: 32, 64, 128, 160, 320, 640)

Ports:
- iCLK  in  1  system clock
- iRST_n  in  1  asynchronous reset, active low
- iSTART  in  1  one-cycle start pulse, driven by the frame buffer's finished output
- iFLASH  in  [479:0][0:639]  frame; pixel (r,c) = iFLASH[r][c]; 1 = foreground
- oBUSY  out  1  high while scanning
- oDONE  out  1  one-cycle pulse when results update
- oVALID_BOX  out  1  at least one foreground pixel in the last scanned frame
- oTOP, oBOTTOM  out  9  min/max foreground row
- oLEFT, oRIGHT  out  10  min/max foreground column
- oCOUNT  out  19  foreground pixel count (0..307200)
- oDROP  out  1  sticky: iSTART arrived while busy

## Operation
- States: IDLE, SCAN.
- IDLE, iSTART=1:
  - go to SCAN
  - row=0, chunk=0
  - clear the working accumulators: found=0, count=0, top/bottom/left/right working registers
- IDLE, iSTART=0: hold.
- SCAN, every cycle:
  - take bits iFLASH[row][chunk*CHUNK +: CHUNK], in ascending column order.
  - count += popcount of the chunk.
  - If the chunk is non-zero:
    - first = lowest set column; last = highest set column
    - if found=0: top=row, left=first, right=last
    - otherwise: left=min(left,first), right=max(right,last)
    - bottom=row; found=1
  - chunk increments; it wraps at 640/CHUNK-1 and then row increments.
- Final chunk (row 479, last chunk):
  - All outputs load from the working values including this chunk.
  - oDONE=1 for one cycle; return to IDLE.
- Empty frame: oVALID_BOX=0; oTOP/oBOTTOM/oLEFT/oRIGHT=0; oCOUNT=0.
- iSTART while in SCAN (including the final-chunk cycle): ignored, and oDROP is set. oDROP clears only on reset.
- Upstream holds iFLASH stable from iSTART until oDONE. This is guaranteed because the buffer takes 307200 cycles per frame and scanning takes 4800 cycles.
- Arithmetic: count is unsigned 19 bits and never saturates, because the maximum is 307200. Comparisons are unsigned.

## Timing
- Reset: all outputs 0, state IDLE, working registers 0.
- iSTART sampled high at edge E0:
  - oBUSY=1 after E0.
  - Chunk k is processed at edge E0+1+k.
  - The final chunk is processed at edge E0+N, where N=307200/CHUNK (4800 at default). oDONE=1, outputs update and oBUSY=0 after this edge.
- oDONE is high for exactly one cycle.
- Earliest accepted next iSTART is the cycle after oDONE.
- Outputs other than oBUSY/oDONE change only at the final-chunk edge or at reset.
- Asynchronous reset mid-scan: state IDLE immediately; outputs 0; no oDONE.

## Configuration
- BBOX_COUNT_EN defined:
  - popcount datapath present
  - oCOUNT reports the foreground count
- BBOX_COUNT_EN undefined:
  - popcount logic and count register are removed
  - oCOUNT is tied to 0
  - box, oVALID_BOX, oDONE and oDROP behaviour is unchanged

## Structure
- Package bbox_pkg:
  - FRAME_W=640, FRAME_H=480
  - typedefs row_t (9 bits), col_t (10 bits), count_t (19 bits)
  - state enum {IDLE, SCAN}
- Sub-module bbox_chunk_scan, combinational:
  - Input: CHUNK-bit slice.
  - Outputs: any, first index, last index, popcount. The popcount output exists only under BBOX_COUNT_EN.
- The top level holds the FSM, row/chunk counters, accumulators and output registers.

## Test plan
- Reset asserted mid-scan -> all outputs 0 at once; no oDONE; next iSTART scans normally.
- Empty frame, iSTART at E0 -> oDONE exactly at E0+4800; oVALID_BOX=0; box=0; oCOUNT=0.
- Single pixel (r=100, c=200) -> oTOP=oBOTTOM=100, oLEFT=oRIGHT=200, oCOUNT=1, oVALID_BOX=1.
- All-ones frame -> box (0, 479, 0, 639); oCOUNT=307200.
- Chunk-boundary case, pixels (5,63), (5,64), (479,0), (0,639) -> box (0, 479, 0, 639); oCOUNT=4. Repeat with CHUNK=32 and CHUNK=640: same results, oDONE at E0+9600 and E0+480 respectively.
- Second iSTART at E0+10 -> ignored; oDROP=1 and remains 1; oDONE still at E0+4800. Build without BBOX_COUNT_EN -> oCOUNT=0, box unchanged.
